// File: rtl/multiword_add_sequencer.sv
// Issue stage that streams a WORDS*WIDTH-bit add/subtract through an external
// WIDTH-bit adder one slice per cycle, LS slice first, and registers the result.
module multiword_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORDS*WIDTH-1:0]   op_a,
  input  logic [WORDS*WIDTH-1:0]   op_b,
  input  logic                     sub,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORDS*WIDTH-1:0]   result,
  output logic                     carry_out,
  output logic                     overflow
);

  localparam int TW   = WORDS * WIDTH;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   a_q, a_d;
  logic [TW-1:0]   b_q, b_d;
  logic [TW-1:0]   res_q, res_d;
  logic            carry_q, carry_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = op_a;
          // Subtract is A + ~B + 1: invert B here, the +1 rides in on carry_in.
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = a_q[idx_q*WIDTH +: WIDTH];
        add_b   = b_q[idx_q*WIDTH +: WIDTH];
        add_cin = carry_q;
        res_d[idx_q*WIDTH +: WIDTH] = add_sum;
        carry_d = add_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          cout_d  = add_cout;
          ovf_d   = (a_q[TW-1] == b_q[TW-1]) && (add_sum[WIDTH-1] != a_q[TW-1]);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign result    = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule
